// File: rtl/alloc_blk_proc_md.sv
// Miss allocation engine: picks a victim way, writes it back if dirty, requests a fill,
// then strobes the new tag/MESI into the set. Optional ALLOC_WB_CNT_EN adds a writeback counter.

`ifndef ASSOC_LV2
`define ASSOC_LV2 4
`endif
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 2
`endif
`ifndef MESI_WID_LV2
`define MESI_WID_LV2 2
`endif
`ifndef TAG_WID_LV2
`define TAG_WID_LV2 20
`endif

module alloc_blk_proc_md #(
    parameter int unsigned ASSOC     = `ASSOC_LV2,
    parameter int unsigned ASSOC_WID = `ASSOC_WID_LV2,
    parameter int unsigned MESI_WID  = `MESI_WID_LV2,
    parameter int unsigned TAG_WID   = `TAG_WID_LV2,
    parameter int unsigned INVALID   = 0,
    parameter int unsigned SHARED    = 1,
    parameter int unsigned EXCLUSIVE = 2,
    parameter int unsigned MODIFIED  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      miss_req,
    input  logic                      cmd_wr,
    input  logic [TAG_WID-1:0]        tag_proc,
    input  logic [ASSOC*MESI_WID-1:0] cache_proc_mesi,
    input  logic [ASSOC*TAG_WID-1:0]  cache_proc_tag,
    input  logic [ASSOC_WID-1:0]      lru_way,
    output logic                      wb_req,
    input  logic                      wb_ack,
    output logic [TAG_WID-1:0]        wb_tag,
    output logic                      fill_req,
    input  logic                      fill_done,
    input  logic                      fill_shared,
    output logic                      alloc_we,
    output logic [ASSOC_WID-1:0]      alloc_way,
    output logic [TAG_WID-1:0]        alloc_tag,
    output logic [MESI_WID-1:0]       alloc_mesi,
    output logic                      busy,
    output logic [15:0]               wb_cnt
);

    localparam logic [MESI_WID-1:0] MesiInv = MESI_WID'(INVALID);
    localparam logic [MESI_WID-1:0] MesiShr = MESI_WID'(SHARED);
    localparam logic [MESI_WID-1:0] MesiExc = MESI_WID'(EXCLUSIVE);
    localparam logic [MESI_WID-1:0] MesiMod = MESI_WID'(MODIFIED);

    typedef enum logic [2:0] {
        StIdle,
        StVictim,
        StWriteback,
        StFill,
        StUpdate
    } state_e;

    state_e               state_q, state_d;
    logic [TAG_WID-1:0]   tag_q, tag_d;
    logic                 wr_q, wr_d;
    logic [ASSOC_WID-1:0] vway_q, vway_d;
    logic [TAG_WID-1:0]   vtag_q, vtag_d;
    logic                 wb_req_q, wb_req_d;
    logic                 fill_req_q, fill_req_d;
    logic                 alloc_we_q, alloc_we_d;
    logic [ASSOC_WID-1:0] alloc_way_q, alloc_way_d;
    logic [TAG_WID-1:0]   alloc_tag_q, alloc_tag_d;
    logic [MESI_WID-1:0]  alloc_mesi_q, alloc_mesi_d;

    logic [ASSOC_WID-1:0] vic_way;
    logic [TAG_WID-1:0]   vic_tag;
    logic [MESI_WID-1:0]  vic_mesi;
    logic                 vic_found;

    // Lowest-index invalid way wins; LRU only when the set is full.
    always_comb begin
        vic_way   = lru_way;
        vic_found = 1'b0;
        for (int i = 0; i < int'(ASSOC); i++) begin
            if (!vic_found && cache_proc_mesi[i*MESI_WID +: MESI_WID] == MesiInv) begin
                vic_found = 1'b1;
                vic_way   = ASSOC_WID'(i);
            end
        end
        vic_tag  = '0;
        vic_mesi = '0;
        for (int i = 0; i < int'(ASSOC); i++) begin
            if (ASSOC_WID'(i) == vic_way) begin
                vic_tag  = cache_proc_tag[i*TAG_WID +: TAG_WID];
                vic_mesi = cache_proc_mesi[i*MESI_WID +: MESI_WID];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        wr_d         = wr_q;
        vway_d       = vway_q;
        vtag_d       = vtag_q;
        alloc_way_d  = alloc_way_q;
        alloc_tag_d  = alloc_tag_q;
        alloc_mesi_d = alloc_mesi_q;
        unique case (state_q)
            StIdle: begin
                if (miss_req) begin
                    state_d = StVictim;
                    tag_d   = tag_proc;
                    wr_d    = cmd_wr;
                end
            end
            StVictim: begin
                vway_d  = vic_way;
                vtag_d  = vic_tag;
                state_d = (vic_mesi == MesiMod) ? StWriteback : StFill;
            end
            StWriteback: begin
                if (wb_ack) state_d = StFill;
            end
            StFill: begin
                if (fill_done) begin
                    state_d      = StUpdate;
                    alloc_way_d  = vway_q;
                    alloc_tag_d  = tag_q;
                    alloc_mesi_d = wr_q ? MesiMod : (fill_shared ? MesiShr : MesiExc);
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Handshake and strobe outputs are registered copies of the next state.
        wb_req_d   = (state_d == StWriteback);
        fill_req_d = (state_d == StFill);
        alloc_we_d = (state_d == StUpdate);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            wr_q         <= 1'b0;
            vway_q       <= '0;
            vtag_q       <= '0;
            wb_req_q     <= 1'b0;
            fill_req_q   <= 1'b0;
            alloc_we_q   <= 1'b0;
            alloc_way_q  <= '0;
            alloc_tag_q  <= '0;
            alloc_mesi_q <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            wr_q         <= wr_d;
            vway_q       <= vway_d;
            vtag_q       <= vtag_d;
            wb_req_q     <= wb_req_d;
            fill_req_q   <= fill_req_d;
            alloc_we_q   <= alloc_we_d;
            alloc_way_q  <= alloc_way_d;
            alloc_tag_q  <= alloc_tag_d;
            alloc_mesi_q <= alloc_mesi_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign wb_req     = wb_req_q;
    assign wb_tag     = vtag_q;
    assign fill_req   = fill_req_q;
    assign alloc_we   = alloc_we_q;
    assign alloc_way  = alloc_way_q;
    assign alloc_tag  = alloc_tag_q;
    assign alloc_mesi = alloc_mesi_q;

`ifdef ALLOC_WB_CNT_EN
    logic        wb_accept;
    logic [15:0] wb_cnt_q, wb_cnt_d;

    assign wb_accept = (state_q == StWriteback) && wb_ack;

    always_comb begin
        wb_cnt_d = wb_cnt_q;
        if (wb_accept && wb_cnt_q != 16'hFFFF) wb_cnt_d = wb_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_cnt_q <= 16'd0;
        else        wb_cnt_q <= wb_cnt_d;
    end

    assign wb_cnt = wb_cnt_q;
`else
    assign wb_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alloc_blk_proc_md.sv
// Directed bench for alloc_blk_proc_md: transaction-level victim/MESI model plus a per-cycle
// compare process; literal expectations pin the model on the headline scenarios.

module tb_alloc_blk_proc_md;

    localparam int ASSOC = 4;
    localparam int AW    = 2;
    localparam int MW    = 2;
    localparam int TW    = 8;
    localparam logic [1:0] MI = 2'd0, MS = 2'd1, ME = 2'd2, MM = 2'd3;

    logic              clk, rst_n;
    logic              miss_req, cmd_wr;
    logic [TW-1:0]     tag_proc;
    logic [ASSOC*MW-1:0] cache_proc_mesi;
    logic [ASSOC*TW-1:0] cache_proc_tag;
    logic [AW-1:0]     lru_way;
    logic              wb_req, wb_ack;
    logic [TW-1:0]     wb_tag;
    logic              fill_req, fill_done, fill_shared;
    logic              alloc_we;
    logic [AW-1:0]     alloc_way;
    logic [TW-1:0]     alloc_tag;
    logic [MW-1:0]     alloc_mesi;
    logic              busy;
    logic [15:0]       wb_cnt;

    alloc_blk_proc_md #(
        .ASSOC    (ASSOC),
        .ASSOC_WID(AW),
        .MESI_WID (MW),
        .TAG_WID  (TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_req       (miss_req),
        .cmd_wr         (cmd_wr),
        .tag_proc       (tag_proc),
        .cache_proc_mesi(cache_proc_mesi),
        .cache_proc_tag (cache_proc_tag),
        .lru_way        (lru_way),
        .wb_req         (wb_req),
        .wb_ack         (wb_ack),
        .wb_tag         (wb_tag),
        .fill_req       (fill_req),
        .fill_done      (fill_done),
        .fill_shared    (fill_shared),
        .alloc_we       (alloc_we),
        .alloc_way      (alloc_way),
        .alloc_tag      (alloc_tag),
        .alloc_mesi     (alloc_mesi),
        .busy           (busy),
        .wb_cnt         (wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] way;
        logic [TW-1:0] tag;
        logic [MW-1:0] mesi;
    } alloc_t;

    alloc_t      exp_q[$];
    alloc_t      cmp_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_alloc = 0;
    logic [15:0] exp_wb_cnt = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // What a miss must allocate, derived directly from the set contents.
    task automatic predict(input logic [ASSOC*MW-1:0] mv, input logic [ASSOC*TW-1:0] tv,
                           input logic [AW-1:0] lru, input logic wr, input logic [TW-1:0] t,
                           input logic fsh, output alloc_t e, output bit nwb,
                           output logic [TW-1:0] wbt);
        int w;
        w = int'(lru);
        for (int i = ASSOC - 1; i >= 0; i--) begin
            if (mv[i*MW +: MW] == MI) w = i;
        end
        e.way  = AW'(w);
        e.tag  = t;
        e.mesi = wr ? MM : (fsh ? MS : ME);
        nwb    = (mv[w*MW +: MW] == MM);
        wbt    = tv[w*TW +: TW];
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("wb_fill_overlap", {31'd0, wb_req && fill_req}, 32'd0);
            if (!busy) check("idle_quiet", {29'd0, wb_req, fill_req, alloc_we}, 32'd0);
            if (alloc_we) begin
                n_alloc++;
                if (exp_q.size() == 0) begin
                    check("unexpected_alloc_we", 32'd1, 32'd0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("alloc_way", {30'd0, alloc_way}, {30'd0, cmp_e.way});
                    check("alloc_tag", {24'd0, alloc_tag}, {24'd0, cmp_e.tag});
                    check("alloc_mesi", {30'd0, alloc_mesi}, {30'd0, cmp_e.mesi});
                end
            end
        end
    end

    task automatic do_miss(input logic [ASSOC*MW-1:0] mv, input logic [ASSOC*TW-1:0] tv,
                           input logic [AW-1:0] lru, input logic wr, input logic [TW-1:0] t,
                           input int wb_dly, input int fill_dly, input logic fsh, input bit dup,
                           output int lat, output int wbc);
        alloc_t        e;
        bit            nwb;
        logic [TW-1:0] wbt;
        int            cyc, fc, exp_lat;
        bit            done;
        predict(mv, tv, lru, wr, t, fsh, e, nwb, wbt);
        exp_q.push_back(e);
        @(posedge clk); #1;
        miss_req = 1'b1; cmd_wr = wr; tag_proc = t;
        cache_proc_mesi = mv; cache_proc_tag = tv; lru_way = lru;
        @(posedge clk); #1;
        miss_req = 1'b0; tag_proc = ~t; cmd_wr = ~wr;
        cyc = 1; wbc = 0; fc = 0; lat = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            if (cyc == 2) begin
                miss_req = dup;
                cache_proc_mesi = ~mv; cache_proc_tag = ~tv; lru_way = ~lru;
            end
            if (cyc == 3) miss_req = 1'b0;
            if (wb_req) begin
                wbc++;
                check("wb_tag", {24'd0, wb_tag}, {24'd0, wbt});
                wb_ack = (wbc == wb_dly + 1);
            end else begin
                wb_ack = 1'b0;
            end
            if (fill_req) begin
                fc++;
                fill_done   = (fc == fill_dly + 1);
                fill_shared = fill_done ? fsh : ~fsh;
            end else begin
                fill_done = 1'b0; fill_shared = 1'b0;
            end
            if (alloc_we) begin
                lat = cyc; done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        wb_ack = 1'b0; fill_done = 1'b0; fill_shared = 1'b0; miss_req = 1'b0;
        if (!done) check("alloc_timeout", 32'd0, 32'd1);
`ifdef ALLOC_WB_CNT_EN
        if (nwb && exp_wb_cnt != 16'hFFFF) exp_wb_cnt++;
`endif
        exp_lat = 3 + fill_dly + (nwb ? wb_dly + 1 : 0);
        check("latency", lat, exp_lat);
        check("wb_cycles", wbc, nwb ? wb_dly + 1 : 0);
        check("wb_cnt", {16'd0, wb_cnt}, {16'd0, exp_wb_cnt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int lat, wbc, base;

    initial begin
        rst_n = 1'b0; miss_req = 1'b0; cmd_wr = 1'b0; tag_proc = '0;
        cache_proc_mesi = '0; cache_proc_tag = '0; lru_way = '0;
        wb_ack = 1'b0; fill_done = 1'b0; fill_shared = 1'b0;
        #12;
        check("reset_outputs", {busy, wb_req, fill_req, alloc_we, alloc_way, alloc_mesi},
              32'd0);
        check("reset_tags_cnt", {alloc_tag, wb_tag, wb_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // {S,I,I,E}: first invalid is way 1, clean, immediate fill.
        do_miss(8'b10_00_00_01, 32'h44_33_22_11, 2'd0, 1'b0, 8'h5A, 0, 0, 1'b0, 1'b0, lat, wbc);
        idle(2);
        check("t1_lat", lat, 3);
        check("t1_way", {30'd0, alloc_way}, 32'd1);
        check("t1_tag", {24'd0, alloc_tag}, 32'h5A);
        check("t1_mesi_hold", {30'd0, alloc_mesi}, 32'd2);
        check("t1_we_low", {31'd0, alloc_we}, 32'd0);

        // All exclusive, LRU way 2, write miss.
        do_miss(8'hAA, 32'hD4_C3_B2_A1, 2'd2, 1'b1, 8'h3C, 0, 1, 1'b0, 1'b0, lat, wbc);
        idle(2);
        check("t2_way", {30'd0, alloc_way}, 32'd2);
        check("t2_mesi", {30'd0, alloc_mesi}, 32'd3);
        check("t2_no_wb", wbc, 0);

        // Way 3 modified, tag 0x11; ack after 4 cycles.
        do_miss(8'b11_01_01_01, 32'h11_77_66_55, 2'd3, 1'b0, 8'h22, 4, 1, 1'b0, 1'b0, lat, wbc);
        idle(2);
        check("t3_wb_cycles", wbc, 5);
        check("t3_way", {30'd0, alloc_way}, 32'd3);
        check("t3_mesi", {30'd0, alloc_mesi}, 32'd2);
`ifdef ALLOC_WB_CNT_EN
        check("t3_wb_cnt", {16'd0, wb_cnt}, 32'd1);
`else
        check("t3_wb_cnt", {16'd0, wb_cnt}, 32'd0);
`endif

        // Shared fill on read; a second miss while busy must be dropped.
        base = n_alloc;
        do_miss(8'b01_01_01_00, 32'h88_99_AA_BB, 2'd1, 1'b0, 8'h77, 0, 2, 1'b1, 1'b1, lat, wbc);
        idle(6);
        check("t4_one_pulse", n_alloc - base, 1);
        check("t4_way", {30'd0, alloc_way}, 32'd0);
        check("t4_mesi", {30'd0, alloc_mesi}, 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a writeback.
        miss_req = 1'b1; cmd_wr = 1'b0; tag_proc = 8'h66;
        cache_proc_mesi = 8'b11_01_01_01; cache_proc_tag = 32'h11_77_66_55; lru_way = 2'd3;
        @(posedge clk); #1;
        miss_req = 1'b0;
        for (int k = 0; k < 10 && !wb_req; k++) begin
            @(posedge clk); #1;
        end
        check("t5_in_wb", {31'd0, wb_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_wb_busy", {30'd0, wb_req, busy}, 32'd0);
        check("t5_rst_cnt", {16'd0, wb_cnt}, 32'd0);
        check("t5_rst_other", {fill_req, alloc_we, alloc_way, alloc_mesi, alloc_tag, wb_tag},
              32'd0);
        exp_wb_cnt = 16'd0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        do_miss(8'b10_00_00_01, 32'h44_33_22_11, 2'd0, 1'b0, 8'h5A, 0, 0, 1'b0, 1'b0, lat, wbc);
        idle(2);
        check("t5_restart_lat", lat, 3);

        // Stray handshake pulses while idle.
        base = n_alloc;
        wb_ack = 1'b1;
        idle(1);
        check("t6_busy_a", {31'd0, busy}, 32'd0);
        wb_ack = 1'b0; fill_done = 1'b1; fill_shared = 1'b1;
        idle(1);
        check("t6_busy_b", {31'd0, busy}, 32'd0);
        fill_done = 1'b0; fill_shared = 1'b0;
        idle(3);
        check("t6_busy_c", {31'd0, busy}, 32'd0);
        check("t6_no_alloc", n_alloc - base, 0);
        check("t6_wb_cnt", {16'd0, wb_cnt}, {16'd0, exp_wb_cnt});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/alloc_blk_proc_md.md
ALLOC_BLK_PROC_MD -- requirements
Module: alloc_blk_proc_md

Interface
REQ-001 SHALL have parameter ASSOC, default `ASSOC_LV2: ways per set, a power of two.
REQ-002 SHALL have parameter ASSOC_WID, default `ASSOC_WID_LV2: way index width, log2(ASSOC).
REQ-003 SHALL have parameter MESI_WID, default `MESI_WID_LV2: MESI field width.
REQ-004 SHALL have parameter TAG_WID, default `TAG_WID_LV2: tag width.
REQ-005 SHALL have parameters INVALID 0, SHARED 1, EXCLUSIVE 2, MODIFIED 3: MESI encodings.
REQ-006 SHALL have the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_req  in  1  processor miss, sampled in IDLE only.
- cmd_wr  in  1  miss is a write; sampled together with miss_req.
- tag_proc  in  TAG_WID  tag of the missing address.
- cache_proc_mesi  in  ASSOC*MESI_WID  set MESI fields; way i at [(i+1)*MESI_WID-1 : i*MESI_WID].
- cache_proc_tag  in  ASSOC*TAG_WID  set tags, packed the same way.
- lru_way  in  ASSOC_WID  LRU way of the set.
- wb_req / wb_ack  out/in  1 / 1  writeback handshake.
- wb_tag  out  TAG_WID  victim tag to write back.
- fill_req / fill_done  out/in  1 / 1  fill handshake.
- fill_shared  in  1  another cache holds the line; valid with fill_done.
- alloc_we  out  1  one-cycle tag/MESI write strobe.
- alloc_way  out  ASSOC_WID  way to write.
- alloc_tag  out  TAG_WID  tag to write.
- alloc_mesi  out  MESI_WID  state to write.
- busy  out  1  high in every state except IDLE.
- wb_cnt  out  16  writeback count; see Configuration.

Function
REQ-007 SHALL implement FSM IDLE, VICTIM, WRITEBACK, FILL, UPDATE; busy = (state != IDLE).
REQ-008 IDLE -> VICTIM when miss_req=1; SHALL latch tag_proc and cmd_wr.
REQ-009 VICTIM (one cycle) SHALL latch victim way, victim tag and victim MESI.
- Victim way = lowest-index way with MESI == INVALID.
- If no way is INVALID, victim way = lru_way.
REQ-010 VICTIM -> WRITEBACK if victim MESI == MODIFIED, else VICTIM -> FILL.
REQ-011 WRITEBACK SHALL drive wb_req=1 and wb_tag=victim tag.
- wb_ack sampled high in WRITEBACK moves the FSM to FILL; this includes the first WRITEBACK cycle.
- wb_ack is ignored in all other states.
REQ-012 FILL SHALL drive fill_req=1.
- fill_done sampled high in FILL moves the FSM to UPDATE and latches fill_shared.
- fill_done is ignored in all other states.
REQ-013 UPDATE (one cycle) SHALL drive alloc_we=1, alloc_way=victim way and alloc_tag=latched tag, then return to IDLE.
REQ-014 alloc_mesi in UPDATE SHALL be:
- MODIFIED if the latched cmd_wr = 1;
- else SHARED if the latched fill_shared = 1;
- else EXCLUSIVE.
REQ-015 Outside UPDATE, alloc_we SHALL be 0; alloc_way, alloc_tag and alloc_mesi hold their last values.
REQ-016 miss_req SHALL be ignored while busy; changes to miss_req, cmd_wr and tag_proc after sampling SHALL have no effect.
REQ-017 Minimum latency is 3 cycles from miss_req sampled to alloc_we with a clean victim and immediate fill_done; each writeback adds at least 1 cycle.
REQ-018 wb_req and fill_req SHALL be registered and never high in the same cycle.

Reset
REQ-019 While rst_n=0, asynchronously and regardless of state (including mid-handshake), the block SHALL set state=IDLE.
REQ-020 While rst_n=0, all outputs SHALL be 0: busy, wb_req, fill_req, alloc_we, alloc_way, alloc_tag, alloc_mesi, wb_tag and wb_cnt.
REQ-021 After rst_n deasserts, the first miss_req SHALL be sampled on the first rising edge.

Configuration
REQ-022 With macro ALLOC_WB_CNT_EN defined, wb_cnt SHALL increment by 1 on each accepted wb_ack and saturate at 16'hFFFF.
REQ-023 Without ALLOC_WB_CNT_EN, wb_cnt SHALL be constant 0 and no counter logic is instantiated.

Verification
REQ-024 Bench SHALL use ASSOC=4, TAG_WID=8 and cover:
- Ways MESI {S,I,I,E}, miss_req with tag 0x5A, fill_done 0 cycles after fill_req, fill_shared=0 -> alloc_we in cycle 3, way 1, tag 0x5A, EXCLUSIVE, wb_req never asserted.
- All ways E, lru_way=2, cmd_wr=1 -> alloc_way 2, alloc_mesi MODIFIED, no writeback.
- Way 3 M with tag 0x11, others S, lru_way=3, wb_ack after 4 cycles -> wb_req high for 5 cycles with wb_tag 0x11, then fill_req; wb_cnt = 1 with ALLOC_WB_CNT_EN, 0 without.
- fill_shared=1 on a read miss -> alloc_mesi SHARED; second miss_req while busy -> ignored, exactly one alloc_we pulse.
- rst_n low during WRITEBACK -> wb_req, busy and wb_cnt are 0 immediately; the next miss restarts from VICTIM.
- Stray wb_ack/fill_done pulses in IDLE -> no state change, no alloc_we.
